qea_host_ctrl: RTL and testbench
================================

Name: qea_host_ctrl

Overview:
- Host-side sequencer that drives QEA's load, start and readback ports in hardware, replacing testbench-driven loading.
- Takes a job config and a valid/ready stream of 64-bit gate-context words.
- Writes the words into QEA's context RAM, initialises state RAM to |0…0>, pulses start, waits for completion, then streams the final state vector out.
- Sits directly upstream and downstream of QEA.

Parameters:
- PE_NUM_WIDTH, 2, log2 of PE_NUM.
- PE_NUM, 4, number of PE lanes per state word.
- STATE_DATA_WIDTH, 64, one complex amplitude: {re[63:32], im[31:0]}, Q2.30 each.
- STATE_ADDR_WIDTH, 16, state RAM address width.
- GATE_CONTEXT_DATA_WIDTH, 64, context word width.
- GATE_CONTEXT_ADDR_WIDTH, 16, context RAM address width.
- MAX_QBIT_WIDTH, 6, width of the qubit count.
- RD_LATENCY, 1, state RAM read latency in cycles (1..3).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_cfg_valid  in  1  job request.
- o_cfg_ready  out  1  high only in IDLE.
- i_cfg_qbit_num  in  MAX_QBIT_WIDTH  qubit count.
- i_cfg_ins_num  in  GATE_CONTEXT_ADDR_WIDTH+1  number of context words.
- o_cfg_err  out  1  one-cycle pulse when a config is rejected.
- i_ctx_valid  in  1  context word valid.
- o_ctx_ready  out  1  context word accepted this cycle.
- i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context word.
- o_qea_start  out  1  start pulse to QEA.
- o_qea_qbit_num  out  MAX_QBIT_WIDTH  latched qubit count.
- o_ctx_en  out  1  context RAM enable.
- o_ctx_wea  out  1  context RAM write enable.
- o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  context RAM address.
- o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  context RAM write data.
- o_state_ena  out  1  state RAM enable.
- o_state_wea  out  1  state RAM write enable.
- o_state_addra  out  STATE_ADDR_WIDTH  state RAM address.
- o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  state RAM write data.
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  state RAM read data.
- i_qea_complete  in  1  QEA done, level.
- o_res_valid  out  1  result word valid.
- i_res_ready  in  1  result consumer ready.
- o_res_data  out  PE_NUM*STATE_DATA_WIDTH  result word.
- o_res_last  out  1  marks the final result word.
- o_busy  out  1  high whenever not in IDLE.
- o_cycles  out  32  execution cycle count of the last job.

Behaviour:
- Reset: all outputs 0 except o_cfg_ready=1; o_qea_qbit_num=0; o_cycles=0; FSM=IDLE. Reset mid-job aborts immediately; no partial result stream resumes.
- Derived word count: N = 2**(qbit_num-PE_NUM_WIDTH).
- Config acceptance: in IDLE, i_cfg_valid accepts the config. Reject with o_cfg_err pulse and stay in IDLE if:
  - qbit_num <= PE_NUM_WIDTH, or
  - qbit_num > STATE_ADDR_WIDTH+PE_NUM_WIDTH, or
  - ins_num > 2**GATE_CONTEXT_ADDR_WIDTH.
- On accept, latch qbit_num and ins_num, then go to CTX_LOAD. If ins_num=0, go straight to STATE_INIT.
- CTX_LOAD:
  - o_ctx_ready=1. Each cycle with i_ctx_valid writes one word: en=wea=1, addr=k, data=i_ctx_data, k counting 0..ins_num-1.
  - Bubbles when valid=0 leave en=wea=0 and addr held.
  - After word ins_num-1, go to STATE_INIT. Words offered outside CTX_LOAD are not accepted.
- STATE_INIT:
  - One write per cycle, ena=wea=1, addr 0..N-1.
  - Data is all zeros except address 0, whose top lane [PE_NUM*64-1 -: 64] = 64'h40000000_00000000 (1.0+0j).
  - Then go to START.
- START: o_qea_start=1 for exactly one cycle; clear the cycle counter; go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - i_qea_complete is ignored for the first 2 WAIT cycles (guards a stale level), then sampled.
  - When complete=1: o_cycles = counter value, go to RD_REQ. The counter saturates at 32'hFFFFFFFF.
- RD_REQ: ena=1, wea=0, addr=j; go to RD_WAIT.
- RD_WAIT: wait RD_LATENCY cycles, capture i_state_dout into o_res_data, go to OUT.
- OUT:
  - o_res_valid=1 and o_res_last=(j==N-1); data held stable until i_res_ready.
  - On handshake: j++ and go to RD_REQ, or go to IDLE after the last word.
  - At most one read is outstanding; worst-case throughput is one word per RD_LATENCY+2 cycles.
- Address ranges: addresses never exceed N-1 or ins_num-1; counters are wide enough that a full 2**16 range does not wrap early.
- Control signals: o_ctx_* and o_state_* are 0 in every state not listed above; o_state_wea is never asserted during readback.

Test Plan:
- qbit=15, ins_num=1897, ctx words streamed back-to-back -> 1897 writes at addr 0..1896 with matching data; 8192 state writes; addr 0 top lane = 40000000_00000000, all else 0; single start pulse.
- Ctx stream with valid toggling 1,0,1,0 -> en/wea follow valid; addresses contiguous with no skips or duplicates.
- Model asserts complete 50 cycles after start; bench holds i_res_ready low 3 cycles per word -> o_cycles=50; readback addr 0..N-1 in order; o_res_data stable while stalled; o_res_last only on word N-1.
- i_qea_complete held high from before start -> ignored for 2 cycles; o_cycles=2 when still high at the third WAIT cycle.
- Configs with qbit=2, qbit=19, and ins_num=65537 -> o_cfg_err pulse; no RAM writes; stays IDLE with o_cfg_ready=1.
- rst_n low during WAIT and again during OUT -> all outputs return to reset values asynchronously; the next job runs correctly from IDLE.

Source files
------------

// File: rtl/qea_host_ctrl.sv
`timescale 1ns/1ps
// Host-side sequencer for QEA: loads gate context, seeds the state RAM with |0..0>,
// launches a run, then streams the final state vector back out one word at a time.
module qea_host_ctrl #(
   parameter int PE_NUM_WIDTH            = 2,
   parameter int PE_NUM                  = 4,
   parameter int STATE_DATA_WIDTH        = 64,
   parameter int STATE_ADDR_WIDTH        = 16,
   parameter int GATE_CONTEXT_DATA_WIDTH = 64,
   parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
   parameter int MAX_QBIT_WIDTH          = 6,
   parameter int RD_LATENCY              = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_cfg_valid,
   output logic                                 o_cfg_ready,
   input  logic [MAX_QBIT_WIDTH-1:0]            i_cfg_qbit_num,
   input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_cfg_ins_num,
   output logic                                 o_cfg_err,
   input  logic                                 i_ctx_valid,
   output logic                                 o_ctx_ready,
   input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
   output logic                                 o_qea_start,
   output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
   output logic                                 o_ctx_en,
   output logic                                 o_ctx_wea,
   output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
   output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
   output logic                                 o_state_ena,
   output logic                                 o_state_wea,
   output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
   input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
   input  logic                                 i_qea_complete,
   output logic                                 o_res_valid,
   input  logic                                 i_res_ready,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_res_data,
   output logic                                 o_res_last,
   output logic                                 o_busy,
   output logic [31:0]                          o_cycles
);

   localparam int SWW = PE_NUM*STATE_DATA_WIDTH;
   localparam int CW  = GATE_CONTEXT_ADDR_WIDTH+1;
   localparam int SW  = STATE_ADDR_WIDTH+1;
   localparam logic [MAX_QBIT_WIDTH-1:0] QMIN    = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
   localparam logic [MAX_QBIT_WIDTH-1:0] QMAX    = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH+PE_NUM_WIDTH);
   localparam logic [CW-1:0]             INS_MAX = {1'b1, {GATE_CONTEXT_ADDR_WIDTH{1'b0}}};
   localparam logic [1:0]                LAT_LAST = 2'(RD_LATENCY-1);
   // |0..0>: amplitude 1.0+0j sits in the top lane of word 0
   localparam logic [SWW-1:0] INIT0 = {STATE_DATA_WIDTH'(64'h40000000_00000000),
                                       {(SWW-STATE_DATA_WIDTH){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_CTX_LOAD, S_STATE_INIT, S_START, S_WAIT, S_RD_REQ, S_RD_WAIT, S_OUT
   } state_t;

   state_t                    state, state_nx;
   logic [MAX_QBIT_WIDTH-1:0] qbit_q;
   logic [CW-1:0]             ins_q, ctx_k;
   logic [SW-1:0]             n_last, st_j;
   logic [31:0]               cnt, cycles_q;
   logic [1:0]                lat_cnt;
   logic [SWW-1:0]            res_q;
   logic                      cfg_err_q;
   logic                      cfg_bad, wait_armed, lat_done, ctx_last, st_last;

   assign cfg_bad    = (i_cfg_qbit_num <= QMIN) || (i_cfg_qbit_num > QMAX) ||
                       (i_cfg_ins_num > INS_MAX);
   // the first two WAIT cycles ignore complete, it may still be high from the last job
   assign wait_armed = cnt >= 32'd2;
   assign lat_done   = lat_cnt == LAT_LAST;
   assign ctx_last   = ctx_k == ins_q - CW'(1);
   assign st_last    = st_j == n_last;

   assign o_cfg_err      = cfg_err_q;
   assign o_qea_qbit_num = qbit_q;
   assign o_cycles       = cycles_q;
   assign o_res_data     = res_q;
   assign o_busy         = state != S_IDLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         qbit_q    <= '0;
         ins_q     <= '0;
         ctx_k     <= '0;
         n_last    <= '0;
         st_j      <= '0;
         cnt       <= '0;
         cycles_q  <= '0;
         lat_cnt   <= '0;
         res_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state     <= state_nx;
         cfg_err_q <= 1'b0;
         case (state)
            S_IDLE: if (i_cfg_valid) begin
               if (cfg_bad) cfg_err_q <= 1'b1;
               else begin
                  qbit_q <= i_cfg_qbit_num;
                  ins_q  <= i_cfg_ins_num;
                  n_last <= (SW'(1) << (i_cfg_qbit_num - QMIN)) - SW'(1);
                  ctx_k  <= '0;
                  st_j   <= '0;
               end
            end
            S_CTX_LOAD:   if (i_ctx_valid) ctx_k <= ctx_k + CW'(1);
            // st_j is reused as the readback index, so rewind it after init
            S_STATE_INIT: st_j <= st_last ? '0 : st_j + SW'(1);
            S_START:      cnt <= '0;
            S_WAIT: begin
               if (cnt != '1) cnt <= cnt + 32'd1;
               if (wait_armed && i_qea_complete) cycles_q <= cnt;
            end
            S_RD_REQ:     lat_cnt <= '0;
            S_RD_WAIT: begin
               lat_cnt <= lat_cnt + 2'd1;
               if (lat_done) res_q <= i_state_dout;
            end
            S_OUT:        if (i_res_ready && !st_last) st_j <= st_j + SW'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx      = state;
      o_cfg_ready   = 1'b0;
      o_ctx_ready   = 1'b0;
      o_ctx_en      = 1'b0;
      o_ctx_wea     = 1'b0;
      o_ctx_addr    = '0;
      o_ctx_data    = '0;
      o_state_ena   = 1'b0;
      o_state_wea   = 1'b0;
      o_state_addra = '0;
      o_state_dina  = '0;
      o_qea_start   = 1'b0;
      o_res_valid   = 1'b0;
      o_res_last    = 1'b0;
      case (state)
         S_IDLE: begin
            o_cfg_ready = 1'b1;
            if (i_cfg_valid && !cfg_bad)
               state_nx = (i_cfg_ins_num == '0) ? S_STATE_INIT : S_CTX_LOAD;
         end
         S_CTX_LOAD: begin
            o_ctx_ready = 1'b1;
            o_ctx_addr  = ctx_k[GATE_CONTEXT_ADDR_WIDTH-1:0];
            o_ctx_data  = i_ctx_data;
            if (i_ctx_valid) begin
               o_ctx_en  = 1'b1;
               o_ctx_wea = 1'b1;
               if (ctx_last) state_nx = S_STATE_INIT;
            end
         end
         S_STATE_INIT: begin
            o_state_ena   = 1'b1;
            o_state_wea   = 1'b1;
            o_state_addra = st_j[STATE_ADDR_WIDTH-1:0];
            o_state_dina  = (st_j == '0) ? INIT0 : '0;
            if (st_last) state_nx = S_START;
         end
         S_START: begin
            o_qea_start = 1'b1;
            state_nx    = S_WAIT;
         end
         S_WAIT: if (wait_armed && i_qea_complete) state_nx = S_RD_REQ;
         S_RD_REQ: begin
            o_state_ena   = 1'b1;
            o_state_addra = st_j[STATE_ADDR_WIDTH-1:0];
            state_nx      = S_RD_WAIT;
         end
         S_RD_WAIT: if (lat_done) state_nx = S_OUT;
         S_OUT: begin
            o_res_valid = 1'b1;
            o_res_last  = st_last;
            if (i_res_ready) state_nx = st_last ? S_IDLE : S_RD_REQ;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_qea_host_ctrl.sv
`timescale 1ns/1ps
// Directed bench for qea_host_ctrl: a behavioural state RAM answers reads, every
// phase of each job is compared cycle by cycle against hand-derived values.
module tb_qea_host_ctrl;
   localparam int SWW = 256;
   localparam logic [SWW-1:0] INIT0 = {64'h40000000_00000000, 192'b0};

   logic            clk = 1'b0, rst_n = 1'b0;
   logic            i_cfg_valid = 1'b0, o_cfg_ready, o_cfg_err;
   logic [5:0]      i_cfg_qbit_num = '0;
   logic [16:0]     i_cfg_ins_num = '0;
   logic            i_ctx_valid = 1'b0, o_ctx_ready;
   logic [63:0]     i_ctx_data = '0;
   logic            o_qea_start;
   logic [5:0]      o_qea_qbit_num;
   logic            o_ctx_en, o_ctx_wea;
   logic [15:0]     o_ctx_addr;
   logic [63:0]     o_ctx_data;
   logic            o_state_ena, o_state_wea;
   logic [15:0]     o_state_addra;
   logic [SWW-1:0]  o_state_dina, i_state_dout;
   logic            i_qea_complete = 1'b0;
   logic            o_res_valid, i_res_ready = 1'b0, o_res_last, o_busy;
   logic [SWW-1:0]  o_res_data;
   logic [31:0]     o_cycles;

   int n_chk = 0;
   int n_err = 0;

   qea_host_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
      .i_cfg_qbit_num(i_cfg_qbit_num), .i_cfg_ins_num(i_cfg_ins_num), .o_cfg_err(o_cfg_err),
      .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
      .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
      .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
      .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
      .o_state_dina(o_state_dina), .i_state_dout(i_state_dout),
      .i_qea_complete(i_qea_complete),
      .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
      .o_res_last(o_res_last), .o_busy(o_busy), .o_cycles(o_cycles)
   );

   always #5 clk = ~clk;

   // state RAM, read latency 1
   logic [SWW-1:0] smem [0:8191];
   logic [SWW-1:0] rd_q = '0;
   assign i_state_dout = rd_q;
   always @(posedge clk) begin
      if (o_state_ena && o_state_wea) smem[o_state_addra[12:0]] <= o_state_dina;
      if (o_state_ena && !o_state_wea) rd_q <= smem[o_state_addra[12:0]];
   end

   function automatic logic [63:0] ctx_word(input int k);
      logic [31:0] kk;
      kk = 32'(k);
      return {16'hA5C3, kk[15:0], kk * 32'h9E3779B1};
   endfunction

   function automatic logic [SWW-1:0] exp_state(input int j);
      return (j == 0) ? INIT0 : '0;
   endfunction

   task automatic test_reset(input string tag);
      logic [10:0] ctl;
      rst_n = 1'b0;
      i_cfg_valid = 1'b0; i_ctx_valid = 1'b0; i_res_ready = 1'b0; i_qea_complete = 1'b0;
      #1;
      ctl = {o_cfg_ready, o_cfg_err, o_ctx_ready, o_qea_start, o_ctx_en, o_ctx_wea,
             o_state_ena, o_state_wea, o_res_valid, o_res_last, o_busy};
      n_chk++;
      if (ctl !== 11'b100_0000_0000) begin
         n_err++; $display("FAIL %s ctrl: got %b want %b", tag, ctl, 11'b100_0000_0000);
      end
      n_chk++;
      if ({o_ctx_addr, o_state_addra, o_qea_qbit_num, o_cycles} !== 70'd0) begin
         n_err++; $display("FAIL %s addr/qbit/cycles: got %h want 0", tag,
                           {o_ctx_addr, o_state_addra, o_qea_qbit_num, o_cycles});
      end
      n_chk++;
      if ({o_ctx_data, o_state_dina, o_res_data} !== '0) begin
         n_err++; $display("FAIL %s data: got nonzero %h want 0", tag, o_res_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send_cfg(input logic [5:0] q, input logic [16:0] ins);
      @(negedge clk);
      i_cfg_valid = 1'b1; i_cfg_qbit_num = q; i_cfg_ins_num = ins;
      #1;
      n_chk++;
      if ({o_cfg_ready, o_busy} !== 2'b10) begin
         n_err++; $display("FAIL cfg_idle: got ready,busy=%b want 10", {o_cfg_ready, o_busy});
      end
      @(negedge clk);
      i_cfg_valid = 1'b0;
      #0;
      n_chk++;
      if ({o_busy, o_qea_qbit_num} !== {1'b1, q}) begin
         n_err++; $display("FAIL cfg_latch: got busy,qbit=%h want %h", {o_busy, o_qea_qbit_num}, {1'b1, q});
      end
   endtask

   task automatic ctx_load(input int ins, input bit toggle);
      int k = 0;
      int c = 0;
      logic [82:0] got, want;
      while (k < ins) begin
         i_ctx_valid = !toggle || (c % 2 == 0);
         i_ctx_data  = ctx_word(k);
         #1;
         n_chk++;
         if (i_ctx_valid) begin
            got  = {o_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data};
            want = {3'b111, 16'(k), ctx_word(k)};
         end else begin
            got  = {o_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, 64'd0};
            want = {3'b100, 16'(k), 64'd0};
         end
         if (got !== want) begin
            n_err++; $display("FAIL ctx_write k=%0d: got %h want %h", k, got, want);
         end
         if (i_ctx_valid) k++;
         c++;
         @(negedge clk);
      end
      i_ctx_valid = 1'b0;
   endtask

   task automatic state_init(input int n);
      logic [275:0] got, want;
      for (int j = 0; j < n; j++) begin
         i_ctx_valid = 1'b1;   // offered outside CTX_LOAD, must be refused
         i_ctx_data  = '1;
         #1;
         got  = {o_ctx_ready, o_ctx_en, o_state_ena, o_state_wea, o_state_addra, o_state_dina};
         want = {4'b0011, 16'(j), exp_state(j)};
         n_chk++;
         if (got !== want) begin
            n_err++; $display("FAIL state_init j=%0d: got %h want %h", j, got, want);
         end
         @(negedge clk);
      end
      i_ctx_valid = 1'b0;
   endtask

   // entry: START cycle; exit: #1 into the first RD_REQ cycle
   task automatic run_job_wait(input int rise_at, input logic [31:0] exp_cyc);
      int w = 0;
      int starts = 0;
      #1;
      n_chk++;
      if ({o_qea_start, o_busy, o_state_ena, o_ctx_en} !== 4'b1100) begin
         n_err++; $display("FAIL start_pulse: got %b want 1100", {o_qea_start, o_busy, o_state_ena, o_ctx_en});
      end
      @(negedge clk);
      while (w < 400) begin
         if (w == rise_at) i_qea_complete = 1'b1;
         #1;
         if (o_qea_start) starts++;
         if (o_state_ena) break;
         @(negedge clk);
         w++;
      end
      i_qea_complete = 1'b0;
      n_chk++;
      if (w !== int'(exp_cyc) + 1) begin
         n_err++; $display("FAIL wait_len: got %0d WAIT cycles want %0d", w, exp_cyc + 1);
      end
      n_chk++;
      if (starts !== 0) begin
         n_err++; $display("FAIL start_once: got %0d extra pulses want 0", starts);
      end
      n_chk++;
      if (o_cycles !== exp_cyc) begin
         n_err++; $display("FAIL o_cycles: got %0d want %0d", o_cycles, exp_cyc);
      end
   endtask

   task automatic readback(input int n, input bit stall);
      int lat;
      logic [SWW-1:0] exp;
      for (int j = 0; j < n; j++) begin
         exp = exp_state(j);
         n_chk++;
         if ({o_state_ena, o_state_wea, o_state_addra, o_res_valid} !== {2'b10, 16'(j), 1'b0}) begin
            n_err++; $display("FAIL rd_req j=%0d: got ena,wea,addr,valid=%h want %h", j,
                              {o_state_ena, o_state_wea, o_state_addra, o_res_valid}, {2'b10, 16'(j), 1'b0});
         end
         lat = 0;
         do begin
            @(negedge clk); #1; lat++;
         end while (!o_res_valid && lat < 8);
         n_chk++;
         if ({o_res_valid, o_state_wea} !== 2'b10 || lat != 2) begin
            n_err++; $display("FAIL rd_latency j=%0d: got valid=%b after %0d cycles want 1 after 2", j, o_res_valid, lat);
         end
         n_chk++;
         if ({o_res_data, o_res_last} !== {exp, j == n - 1}) begin
            n_err++; $display("FAIL res_word j=%0d: got %h last=%b want %h last=%b", j,
                              o_res_data, o_res_last, exp, j == n - 1);
         end
         if (stall) begin
            repeat (3) begin
               @(negedge clk); #1;
               n_chk++;
               if ({o_res_valid, o_res_data, o_res_last, o_state_ena} !== {1'b1, exp, j == n - 1, 1'b0}) begin
                  n_err++; $display("FAIL res_stall j=%0d: got valid=%b data=%h want valid=1 data=%h", j,
                                    o_res_valid, o_res_data, exp);
               end
            end
         end
         i_res_ready = 1'b1;
         @(negedge clk);
         i_res_ready = 1'b0;
         #1;
      end
      n_chk++;
      if ({o_busy, o_cfg_ready, o_res_valid} !== 3'b010) begin
         n_err++; $display("FAIL job_done: got busy,ready,valid=%b want 010", {o_busy, o_cfg_ready, o_res_valid});
      end
   endtask

   task automatic test_cfg_reject();
      logic [5:0]  qs [3] = '{6'd2, 6'd19, 6'd4};
      logic [16:0] is [3] = '{17'd4, 17'd4, 17'd65537};
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         i_cfg_valid = 1'b1; i_cfg_qbit_num = qs[t]; i_cfg_ins_num = is[t];
         i_ctx_valid = 1'b1;
         #1;
         n_chk++;
         if ({o_cfg_ready, o_busy, o_cfg_err, o_ctx_ready} !== 4'b1000) begin
            n_err++; $display("FAIL rej%0d_offer: got %b want 1000", t, {o_cfg_ready, o_busy, o_cfg_err, o_ctx_ready});
         end
         @(negedge clk);
         i_cfg_valid = 1'b0;
         #1;
         n_chk++;
         if ({o_cfg_err, o_cfg_ready, o_busy, o_ctx_en, o_state_ena} !== 5'b11000) begin
            n_err++; $display("FAIL rej%0d_err: got %b want 11000", t, {o_cfg_err, o_cfg_ready, o_busy, o_ctx_en, o_state_ena});
         end
         @(negedge clk); #1;
         n_chk++;
         if ({o_cfg_err, o_cfg_ready, o_busy, o_ctx_en, o_state_ena} !== 5'b01000) begin
            n_err++; $display("FAIL rej%0d_pulse: got %b want 01000", t, {o_cfg_err, o_cfg_ready, o_busy, o_ctx_en, o_state_ena});
         end
         i_ctx_valid = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      send_cfg(6'd15, 17'd1897);
      ctx_load(1897, 1'b0);
      state_init(8192);
      run_job_wait(10, 32'd10);
      readback(8192, 1'b0);
   endtask

   task automatic test_ctx_bubbles();
      send_cfg(6'd3, 17'd6);
      ctx_load(6, 1'b1);
      state_init(2);
      run_job_wait(5, 32'd5);
      readback(2, 1'b0);
   endtask

   // complete rises after 50 full WAIT cycles; ins_num=0 skips CTX_LOAD
   task automatic test_wait_stall();
      send_cfg(6'd4, 17'd0);
      state_init(4);
      run_job_wait(50, 32'd50);
      readback(4, 1'b1);
   endtask

   task automatic test_stale_complete();
      i_qea_complete = 1'b1;
      send_cfg(6'd3, 17'd2);
      ctx_load(2, 1'b0);
      state_init(2);
      run_job_wait(-1, 32'd2);
      readback(2, 1'b0);
   endtask

   task automatic test_reset_mid();
      send_cfg(6'd3, 17'd1);
      ctx_load(1, 1'b0);
      state_init(2);
      @(negedge clk);
      @(negedge clk);
      #1;
      n_chk++;
      if ({o_busy, o_state_ena, o_res_valid} !== 3'b100) begin
         n_err++; $display("FAIL in_wait: got %b want 100", {o_busy, o_state_ena, o_res_valid});
      end
      test_reset("rst_wait");
      send_cfg(6'd3, 17'd1);
      ctx_load(1, 1'b0);
      state_init(2);
      run_job_wait(4, 32'd4);
      @(negedge clk);
      @(negedge clk);
      #1;
      n_chk++;
      if ({o_res_valid, o_res_data} !== {1'b1, INIT0}) begin
         n_err++; $display("FAIL in_out: got valid=%b data=%h want 1 %h", o_res_valid, o_res_data, INIT0);
      end
      test_reset("rst_out");
      send_cfg(6'd4, 17'd3);
      ctx_load(3, 1'b0);
      state_init(4);
      run_job_wait(7, 32'd7);
      readback(4, 1'b0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset("reset");
      test_cfg_reject();
      test_back_to_back();
      test_ctx_bubbles();
      test_wait_stall();
      test_stale_complete();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
